fifo_read_packer: RTL and testbench

- Read-side consumer of the async FIFO, in the read_clk domain.
- Pops data-wide words through the FIFO read port (read_inc / read_empty / read_data) and packs ratio consecutive words into one wide word.
- Presents the wide word on a valid/ready stream.
- A flush request drains the FIFO and emits any partial word with a lane count, so downstream logic gets whole frames without per-word handshaking.

---
 rtl/fifo_read_packer_if.sv | 28 ++
 rtl/fifo_read_packer.sv | 101 ++++++++++
 tb/tb_fifo_read_packer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_packer_if.sv
// Bundle of the FIFO read port, flush handshake and packed output stream
// seen by fifo_read_packer; master is the packer side, slave its environment.
interface fifo_read_packer_if #(
    parameter int data  = 8,
    parameter int ratio = 4
);
    localparam int cw = $clog2(ratio) + 1;

    logic                    read_empty;
    logic [data-1:0]         read_data;
    logic                    read_inc;
    logic                    flush;
    logic                    flush_done;
    logic [data*ratio-1:0]   out_data;
    logic [cw-1:0]           out_count;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  read_empty, read_data, flush, out_ready,
        output read_inc, flush_done, out_data, out_count, out_valid
    );

    modport slave (
        output read_empty, read_data, flush, out_ready,
        input  read_inc, flush_done, out_data, out_count, out_valid
    );
endinterface

// File: rtl/fifo_read_packer.sv
// Read-side packer: pops FIFO words, packs ratio of them into one wide word,
// and on flush drains the FIFO and emits any partial word with its lane count.
module fifo_read_packer #(
    parameter int data  = 8,
    parameter int ratio = 4
) (
    input logic                read_clk,
    input logic                read_rst,
    fifo_read_packer_if.master bus
);
    localparam int cw = $clog2(ratio) + 1;
    localparam int lw = cw - 1;
    localparam logic [lw-1:0] last_lane = lw'(ratio - 1);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] DRAIN  = 1'b1;

    logic [data*ratio-1:0] acc;
    logic [data*ratio-1:0] acc_masked;
    logic [lw-1:0]         cnt;
    logic [0:0]            mode;
    logic [data*ratio-1:0] out_data_q;
    logic [cw-1:0]         out_count_q;
    logic                  out_valid_q;
    logic                  flush_done_q;

    logic flush_pend;
    logic slot_free;
    logic emit_partial;
    logic drain_idle;
    logic pop;
    logic completing;

    assign flush_pend   = (mode == DRAIN);
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign emit_partial = flush_pend && bus.read_empty && slot_free && (cnt != '0);
    assign drain_idle   = flush_pend && bus.read_empty && (cnt == '0);
    assign completing   = pop && (cnt == last_lane);

    // A full lane counter only blocks on a busy output slot; partial lanes never do.
    assign pop = read_rst && !bus.read_empty
              && ((cnt != last_lane) || slot_free) && !emit_partial;

    assign bus.read_inc   = pop;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.flush_done = flush_done_q;

    // Lanes at or above cnt may hold words from an earlier packet; zero them on emit.
    always_comb begin
        // NOTE: default assignment first so no path through the loop infers a latch.
        acc_masked = '0;
        for (int i = 0; i < ratio; i++) begin
            if (i < int'(cnt)) acc_masked[i*data +: data] = acc[i*data +: data];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the synchronous
    // reset also clears acc so a word interrupted by reset leaves no stale lanes.
    always_ff @(posedge read_clk) begin
        if (!read_rst) begin
            acc          <= '0;
            cnt          <= '0;
            mode         <= NORMAL;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;

            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

            if (pop) begin
                acc[int'(cnt)*data +: data] <= bus.read_data;
                if (completing) begin
                    out_data_q  <= {bus.read_data, acc[data*(ratio-1)-1:0]};
                    out_count_q <= cw'(ratio);
                    out_valid_q <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (emit_partial) begin
                out_data_q  <= acc_masked;
                out_count_q <= {1'b0, cnt};
                out_valid_q <= 1'b1;
                cnt         <= '0;
            end

            // A flush seen while one is already pending is ignored.
            if (emit_partial || drain_idle) begin
                mode         <= NORMAL;
                flush_done_q <= 1'b1;
            end else if (bus.flush && !flush_pend) begin
                mode <= DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: a queue-backed FIFO feeds the DUT and a
// packet-level model predicts every accepted output word.
module tb_fifo_read_packer;
    localparam int DATA  = 8;
    localparam int RATIO = 4;
    localparam int CW    = $clog2(RATIO) + 1;
    localparam int OW    = DATA * RATIO;

    typedef struct {
        logic [OW-1:0] data;
        int            count;
    } pkt_t;

    logic clk = 1'b0;
    logic read_rst;
    always #5 clk = ~clk;

    fifo_read_packer_if #(.data(DATA), .ratio(RATIO)) dif ();

    fifo_read_packer #(.data(DATA), .ratio(RATIO)) dut (
        .read_clk (clk),
        .read_rst (read_rst),
        .bus      (dif.master)
    );

    logic [DATA-1:0] fifo_q[$];
    logic [DATA-1:0] pend_q[$];
    pkt_t            exp_q[$];
    pkt_t            rcv_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int pop_cnt     = 0;
    int vcyc        = 0;
    int fd_cnt      = 0;
    int run         = 0;
    int max_run     = 0;

    logic          held = 1'b0;
    logic [OW-1:0] held_data;
    logic [CW-1:0] held_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Packet model: every RATIO pushed words form one packet; a flush cuts the rest.
    function automatic void model_cut();
        pkt_t p;
        p.data  = '0;
        p.count = pend_q.size();
        for (int i = 0; i < pend_q.size(); i++) p.data[i*DATA +: DATA] = pend_q[i];
        if (p.count > 0) exp_q.push_back(p);
        pend_q.delete();
    endfunction

    function automatic void model_push(input logic [DATA-1:0] w);
        pend_q.push_back(w);
        if (pend_q.size() == RATIO) model_cut();
    endfunction

    task automatic push(input logic [DATA-1:0] w);
        fifo_q.push_back(w);
        model_push(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rcv(input int n, input int budget, input string name);
        int k = 0;
        while (rcv_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(rcv_q.size()), 64'(n));
    endtask

    // FIFO model: the head advances at the edge where read_inc was high.
    always @(posedge clk) begin
        logic p;
        p = dif.read_inc;
        #1;
        if (p && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        dif.read_empty = (fifo_q.size() == 0);
        dif.read_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Compare process: every accepted word against the model, plus hold stability.
    always @(negedge clk) begin
        if (read_rst) begin
            if (held) begin
                check("hold_valid", 64'(dif.out_valid), 64'd1);
                if (dif.out_valid) begin
                    check("hold_data", 64'(dif.out_data), 64'(held_data));
                    check("hold_count", 64'(dif.out_count), 64'(held_count));
                end
            end
            if (dif.out_valid) begin
                vcyc++;
                if (dif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got data 0x%0h count %0d, required no output",
                                 dif.out_data, dif.out_count);
                    end else begin
                        pkt_t e;
                        e = exp_q.pop_front();
                        check("out_data", 64'(dif.out_data), 64'(e.data));
                        check("out_count", 64'(dif.out_count), 64'(e.count));
                    end
                    rcv_q.push_back('{dif.out_data, int'(dif.out_count)});
                end
            end
            held       = dif.out_valid && !dif.out_ready;
            held_data  = dif.out_data;
            held_count = dif.out_count;
            if (dif.flush_done) fd_cnt++;
            run = dif.read_inc ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end else begin
            held = 1'b0;
            run  = 0;
        end
    end

    initial begin
        int base;
        int v0;
        int f0;
        int p0;
        int k;
        logic [OW-1:0] t2_exp [4];
        t2_exp = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

        read_rst      = 1'b0;
        dif.flush     = 1'b0;
        dif.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(dif.out_valid), 64'd0);
        check("rst_out_count", 64'(dif.out_count), 64'd0);
        check("rst_out_data", 64'(dif.out_data), 64'd0);
        check("rst_flush_done", 64'(dif.flush_done), 64'd0);
        check("rst_read_inc", 64'(dif.read_inc), 64'd0);
        read_rst = 1'b1;
        tick();

        // Single packet, downstream always ready.
        base = rcv_q.size();
        v0   = vcyc;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_rcv(base + 1, 20, "t1_outputs");
        repeat (3) tick();
        check("t1_data", 64'(rcv_q[base].data), 64'h44332211);
        check("t1_count", 64'(rcv_q[base].count), 64'd4);
        check("t1_valid_cycles", 64'(vcyc - v0), 64'd1);

        // Sixteen back-to-back words.
        base = rcv_q.size();
        for (int i = 0; i < 16; i++) push(DATA'(i));
        wait_rcv(base + 4, 60, "t2_outputs");
        repeat (3) tick();
        check("t2_pop_run", 64'(max_run), 64'd16);
        for (int i = 0; i < 4; i++) check("t2_data", 64'(rcv_q[base+i].data), 64'(t2_exp[i]));

        // Back-pressure right after the first output.
        base = rcv_q.size();
        for (int i = 0; i < 8; i++) push(DATA'(i));
        k = 0;
        while (!dif.out_valid && k < 30) begin
            tick();
            k++;
        end
        check("t3_first_valid", 64'(dif.out_valid), 64'd1);
        dif.out_ready = 1'b0;
        p0 = pop_cnt;
        repeat (10) tick();
        check("t3_stall_pops", 64'(pop_cnt - p0), 64'd3);
        check("t3_read_inc_low", 64'(dif.read_inc), 64'd0);
        check("t3_valid_held", 64'(dif.out_valid), 64'd1);
        check("t3_held_data", 64'(dif.out_data), 64'h03020100);
        dif.out_ready = 1'b1;
        wait_rcv(base + 2, 20, "t3_outputs");
        check("t3_second_data", 64'(rcv_q[base+1].data), 64'h07060504);

        // Partial word on flush.
        base = rcv_q.size();
        f0   = fd_cnt;
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (6) tick();
        dif.flush = 1'b1;
        model_cut();
        tick();
        dif.flush = 1'b0;
        k = 0;
        while (!dif.flush_done && k < 20) begin
            tick();
            k++;
        end
        check("t4_flush_done", 64'(dif.flush_done), 64'd1);
        check("t4_valid_with_done", 64'(dif.out_valid), 64'd1);
        check("t4_count_live", 64'(dif.out_count), 64'd3);
        check("t4_data_live", 64'(dif.out_data), 64'h00C3B2A1);
        repeat (3) tick();
        check("t4_done_pulses", 64'(fd_cnt - f0), 64'd1);
        check("t4_rcv_data", 64'(rcv_q[base].data), 64'h00C3B2A1);
        check("t4_rcv_count", 64'(rcv_q[base].count), 64'd3);

        // Flush with nothing buffered.
        v0 = vcyc;
        f0 = fd_cnt;
        dif.flush = 1'b1;
        model_cut();
        tick();
        dif.flush = 1'b0;
        repeat (5) tick();
        check("t5_done_pulses", 64'(fd_cnt - f0), 64'd1);
        check("t5_no_output", 64'(vcyc - v0), 64'd0);

        // Reset in the middle of a word.
        base = rcv_q.size();
        push(8'h91); push(8'h92);
        repeat (5) tick();
        read_rst = 1'b0;
        fifo_q.push_back(8'h99);
        tick();
        check("t6_read_inc_in_reset", 64'(dif.read_inc), 64'd0);
        check("t6_valid_in_reset", 64'(dif.out_valid), 64'd0);
        fifo_q.delete();
        pend_q.delete();
        repeat (2) tick();
        read_rst = 1'b1;
        tick();
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        wait_rcv(base + 1, 20, "t6_outputs");
        repeat (4) tick();
        check("t6_only_one", 64'(rcv_q.size()), 64'(base + 1));
        check("t6_data", 64'(rcv_q[base].data), 64'h8D7C6B5A);

        repeat (5) tick();
        check("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
